rf_wb_arbiter: RTL and testbench

- Owns the single register-file write port (W_en/W_addr/W_data), sharing it between two writeback requesters: A = ALU writeback, B = memory/load writeback.
- Round-robin arbitration with valid/ready handshakes and registered outputs.
- Contains a clear sequencer that zeroes registers 1..NUM_REGS-1 through the write port on request, one register per cycle.
- Sits between the pipeline writeback stage and the register file.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_wb_arbiter_if.sv | 34 +++
 rtl/rf_rr_arb2.sv | 15 +
 rtl/rf_wb_arbiter.sv | 112 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the register-file writeback arbiter.
package rf_pkg;

  localparam int RF_WIDTH      = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int REG_ZERO      = 0;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester / register-file write port bundle; master drives requests, slave is the arbiter.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [WIDTH-1:0]      a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [WIDTH-1:0]      b_data;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  W_en;
  logic [ADDR_WIDTH-1:0] W_addr;
  logic [WIDTH-1:0]      W_data;
  logic                  last_grant_b;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_req,
    input  a_ready, b_ready, clr_busy, W_en, W_addr, W_data, last_grant_b
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_req,
    output a_ready, b_ready, clr_busy, W_en, W_addr, W_data, last_grant_b
  );

endinterface

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin grant: combinational ready pair, at most one high; the side not
// granted last wins a tie, and inhibit forces both low.
module rf_rr_arb2 (
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic last_grant_b_i,
  input  logic inhibit_i,
  output logic a_ready_o,
  output logic b_ready_o
);

  assign a_ready_o = ~inhibit_i & a_valid_i & (~b_valid_i | last_grant_b_i);
  assign b_ready_o = ~inhibit_i & b_valid_i & (~a_valid_i | ~last_grant_b_i);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback with 1-cycle
// registered writes, and sweeps registers 1..NUM_REGS-1 to zero on a clear request.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input logic            clock,
  input logic            reset,
  rf_wb_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_LAST = (ADDR_WIDTH+1)'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_R0  = ADDR_WIDTH'(REG_ZERO);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [WIDTH-1:0]      w_data_q, w_data_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  last_grant_b_q, last_grant_b_d;
  logic                  a_rdy, b_rdy, inhibit;

  assign inhibit = ~reset | bus.clr_req | (state_q == ST_CLEAR);

  rf_rr_arb2 u_arb (
    .a_valid_i      (bus.a_valid),
    .b_valid_i      (bus.b_valid),
    .last_grant_b_i (last_grant_b_q),
    .inhibit_i      (inhibit),
    .a_ready_o      (a_rdy),
    .b_ready_o      (b_rdy)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    w_en_d         = 1'b0;
    w_addr_d       = w_addr_q;
    w_data_d       = w_data_q;
    clr_busy_d     = clr_busy_q;
    last_grant_b_d = last_grant_b_q;
    case (state_q)
      ST_ARB: begin
        if (bus.clr_req) begin
          state_d    = ST_CLEAR;
          clr_busy_d = 1'b1;
          cnt_d      = CNT_ONE;
        end else if (a_rdy) begin
          last_grant_b_d = 1'b0;
          // r0 is hardwired zero: the handshake completes but nothing is written
          if (bus.a_addr != ADDR_R0) begin
            w_en_d   = 1'b1;
            w_addr_d = bus.a_addr;
            w_data_d = bus.a_data;
          end
        end else if (b_rdy) begin
          last_grant_b_d = 1'b1;
          if (bus.b_addr != ADDR_R0) begin
            w_en_d   = 1'b1;
            w_addr_d = bus.b_addr;
            w_data_d = bus.b_data;
          end
        end
      end
      ST_CLEAR: begin
        w_en_d   = 1'b1;
        w_addr_d = cnt_q[ADDR_WIDTH-1:0];
        w_data_d = '0;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_ARB;
          clr_busy_d = 1'b0;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_ARB;
      cnt_q          <= CNT_ONE;
      w_en_q         <= 1'b0;
      w_addr_q       <= '0;
      w_data_q       <= '0;
      clr_busy_q     <= 1'b0;
      last_grant_b_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      w_en_q         <= w_en_d;
      w_addr_q       <= w_addr_d;
      w_data_q       <= w_data_d;
      clr_busy_q     <= clr_busy_d;
      last_grant_b_q <= last_grant_b_d;
    end
  end

  assign bus.a_ready      = a_rdy;
  assign bus.b_ready      = b_rdy;
  assign bus.W_en         = w_en_q;
  assign bus.W_addr       = w_addr_q;
  assign bus.W_data       = w_data_q;
  assign bus.clr_busy     = clr_busy_q;
  assign bus.last_grant_b = last_grant_b_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and random writeback traffic against a queue-based model of the arbiter.
module tb_rf_wb_arbiter;

  logic clock;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state: pending clear addresses and the expected registered outputs
  int          clr_q[$];
  int          wen_log[$];
  bit          m_last_b;
  bit          exp_wen;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  bit          acc_a, acc_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit ea, eb;
    @(negedge clock);
    ea = rst_n && clr_q.size() == 0 && bus.a_valid && (!bus.b_valid || m_last_b) && !bus.clr_req;
    eb = rst_n && clr_q.size() == 0 && bus.b_valid && (!bus.a_valid || !m_last_b) && !bus.clr_req;
    check("a_ready", 32'(bus.a_ready), 32'(ea));
    check("b_ready", 32'(bus.b_ready), 32'(eb));
    acc_a = ea;
    acc_b = eb;
    if (!rst_n) begin
      clr_q.delete();
      exp_wen  = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      m_last_b = 1'b1;
    end else if (clr_q.size() != 0) begin
      exp_wen  = 1'b1;
      exp_addr = 5'(clr_q.pop_front());
      exp_data = '0;
    end else if (bus.clr_req) begin
      exp_wen = 1'b0;
      for (int r = 1; r < 32; r++) clr_q.push_back(r);
    end else if (ea) begin
      m_last_b = 1'b0;
      exp_wen  = (bus.a_addr != 5'd0);
      if (exp_wen) begin
        exp_addr = bus.a_addr;
        exp_data = bus.a_data;
      end
    end else if (eb) begin
      m_last_b = 1'b1;
      exp_wen  = (bus.b_addr != 5'd0);
      if (exp_wen) begin
        exp_addr = bus.b_addr;
        exp_data = bus.b_data;
      end
    end else begin
      exp_wen = 1'b0;
    end
    @(posedge clock);
    #1;
    check("W_en", 32'(bus.W_en), 32'(exp_wen));
    if (exp_wen || !rst_n) begin
      check("W_addr", 32'(bus.W_addr), 32'(exp_addr));
      check("W_data", bus.W_data, exp_data);
    end
    check("clr_busy", 32'(bus.clr_busy), 32'(clr_q.size() != 0));
    check("last_grant_b", 32'(bus.last_grant_b), 32'(m_last_b));
    if (bus.W_en) wen_log.push_back(int'(bus.W_addr));
  endtask

  initial begin
    int busy_cnt;
    int first_a;
    bit injected;

    vectors     = 0;
    miscompares = 0;
    m_last_b    = 1'b1;
    exp_wen     = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
    rst_n       = 1'b0;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.clr_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // A alone
    bus.a_valid = 1'b1; bus.a_addr = 5'd8; bus.a_data = 32'hDEADBEEF;
    tick();
    check("t1_accept", 32'(acc_a), 32'd1);
    check("t1_addr", 32'(bus.W_addr), 32'd8);
    check("t1_data", bus.W_data, 32'hDEADBEEF);
    check("t1_last_b", 32'(bus.last_grant_b), 32'd0);
    bus.a_valid = 1'b0;
    tick();

    // both valid from a fresh reset: grants alternate starting with A
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd9;  bus.a_data = 32'd1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 32'd2;
    wen_log.delete();
    for (int i = 0; i < 4; i++) tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    check("alt_count", 32'(wen_log.size()), 32'd4);
    if (wen_log.size() == 4) begin
      check("alt_0", 32'(wen_log[0]), 32'd9);
      check("alt_1", 32'(wen_log[1]), 32'd10);
      check("alt_2", 32'(wen_log[2]), 32'd9);
      check("alt_3", 32'(wen_log[3]), 32'd10);
    end

    // B to r0: accepted but not written
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'd5;
    tick();
    check("r0_accept", 32'(acc_b), 32'd1);
    check("r0_wen", 32'(bus.W_en), 32'd0);
    check("r0_last_b", 32'(bus.last_grant_b), 32'd1);
    bus.b_valid = 1'b0;
    tick();

    // clear with a competing A request and a redundant clr_req mid-sweep
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'd7;
    bus.clr_req = 1'b1;
    tick();
    check("clr_a_blocked", 32'(acc_a), 32'd0);
    bus.clr_req = 1'b0;
    busy_cnt = bus.clr_busy ? 1 : 0;
    first_a  = -1;
    injected = 1'b0;
    wen_log.delete();
    for (int i = 0; i < 33; i++) begin
      tick();
      bus.clr_req = 1'b0;
      if (acc_a && first_a < 0) begin
        first_a = i;
        bus.a_valid = 1'b0;
      end
      if (bus.clr_busy) busy_cnt++;
      if (bus.W_en && bus.W_addr == 5'd5 && !injected) begin
        bus.clr_req = 1'b1;
        injected = 1'b1;
      end
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    check("clr_first_a", 32'(first_a), 32'd31);
    // the final entry is A's own write of r3 after the sweep
    check("clr_wen_count", 32'(wen_log.size()), 32'd32);
    for (int k = 0; k < 31 && k < wen_log.size(); k++)
      check("clr_seq", 32'(wen_log[k]), 32'(k + 1));

    // reset aborts a sweep at r12
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 40 && !(bus.W_en && bus.W_addr == 5'd12); i++) tick();
    check("abort_at12", 32'(bus.W_addr), 32'd12);
    rst_n = 1'b0;
    tick();
    check("abort_wen", 32'(bus.W_en), 32'd0);
    check("abort_busy", 32'(bus.clr_busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    bus.a_valid = 1'b1; bus.a_addr = 5'd17; bus.a_data = 32'h1234;
    bus.b_valid = 1'b1; bus.b_addr = 5'd18; bus.b_data = 32'h5678;
    tick();
    check("post_reset_a_wins", 32'(acc_a), 32'd1);
    check("post_reset_addr", 32'(bus.W_addr), 32'd17);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();

    // random traffic honouring the hold-until-ready contract
    for (int i = 0; i < 600; i++) begin
      if (!bus.a_valid && $urandom_range(0, 1) == 1) begin
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'($urandom_range(0, 31));
        bus.a_data  = $urandom;
      end
      if (!bus.b_valid && $urandom_range(0, 1) == 1) begin
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'($urandom_range(0, 31));
        bus.b_data  = $urandom;
      end
      bus.clr_req = ($urandom_range(0, 63) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      tick();
      if (acc_a) bus.a_valid = 1'b0;
      if (acc_b) bus.b_valid = 1'b0;
    end
    bus.clr_req = 1'b0;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
